eight_bit_adder_substractor: RTL and testbench
==============================================

Name: eight_bit_adder_substractor

Overview:
- 8-bit unsigned/two's-complement adder-subtractor with registered outputs.
- Datapath leaf in the cruise-control arithmetic path.
- `sel` chooses `a+b` or `a-b`; `enable` gates the result register.
- Built as a ripple-carry chain of full adders, with the `b` operand conditionally inverted.

Parameters:
- None. Width is fixed at 8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  [0:7]  operand A; bit 0 is the MSB, bit 7 is the LSB.
- b  input  [0:7]  operand B; same ordering as `a`.
- sel  input  1  0 = add (a+b), 1 = subtract (a-b).
- enable  input  1  1 = capture the new result on the clock edge; 0 = hold.
- s  output  [0:7]  registered sum/difference; bit 0 is the MSB.
- cout  output  1  registered carry out of the MSB stage.
- ovf  output  1  registered signed-overflow flag.

Behaviour:
- Ordering: all vectors are declared [0:7] with index 0 as MSB. Numeric value of `a` = a[0]*128 + … + a[7]*1.
- Combinational core:
  - `bx[i] = b[i] XOR sel`.
  - Carry-in to the LSB stage (index 7) = `sel`.
  - Ripple runs from index 7 toward index 0.
  - `sum = (a + bx + sel) mod 256`.
  - `c8` = carry out of the index-0 stage.
- Add (sel=0):
  - s = (a+b) mod 256.
  - cout = 1 iff a+b ≥ 256.
- Subtract (sel=1):
  - s = (a−b) mod 256.
  - cout = 1 iff a ≥ b unsigned (no borrow).
  - cout = 0 on borrow.
- ovf = carry into the MSB stage XOR carry out of the MSB stage (signed overflow).
- Register stage:
  - On rising clk with enable=1: s←sum, cout←c8, ovf←v.
  - With enable=0: all outputs hold their previous values.
- Latency: exactly 1 clock from operands/sel/enable to outputs. No combinational input-to-output path.
- Reset: rst=1 forces s=0, cout=0, ovf=0 immediately, independent of clk.
  - Reset dominates enable.
  - On the first edge after rst deasserts, normal capture resumes.
- Mid-stream sel change: takes effect on the next enabled edge; no pipeline flush required.
- Wrap-around:
  - 255+1 → s=0, cout=1.
  - 0−1 → s=255, cout=0.
  - x−x → s=0, cout=1.

Decomposition:
- Shared package: constant `AS_WIDTH = 8`; opcode constants `OP_ADD = 1'b0`, `OP_SUB = 1'b1`.
- One sub-module: `full_adder` (ports a, b, cin, sum, cout), instantiated 8 times by generate.
- Operand inversion, overflow logic and the output register stay in the top module.

Test Plan:
- Reset: assert rst with nonzero outputs → s=0, cout=0, ovf=0 without a clock edge. Release rst → first enabled edge captures.
- Unsigned add near wrap, sel=0, enable=1, one case per clock:
  - 253+2 → s=255, cout=0.
  - 253+3 → s=0, cout=1.
  - 253+4 → s=1, cout=1.
  - 254+2 → s=0, cout=1.
  - 254+4 → s=2, cout=1.
- Subtract, sel=1:
  - 8−2 → s=6, cout=1.
  - 9−4 → s=5, cout=1.
  - 10−3 → s=7, cout=1.
  - 0−0 → s=0, cout=1.
  - 2−8 → s=250, cout=0.
- Enable hold: load 8−2 (s=6), then drop enable and apply 10−4 for 3 clocks → s stays 6. Re-enable → s=6 from 10−4 with cout=1, confirming capture.
- Signed overflow:
  - 127+1 (sel=0) → s=128, ovf=1, cout=0.
  - 128−1 (sel=1) → s=127, ovf=1, cout=1.
  - 100+20 → ovf=0.
- Latency: change operands mid-cycle → s updates only at the next rising clk, never before.

Source files
------------

// File: rtl/eight_bit_adder_substractor_pkg.sv
// Shared constants for the 8-bit adder/subtractor datapath leaf.
// Opcode values match the sel pin: 0 adds, 1 subtracts.
package eight_bit_adder_substractor_pkg;

   localparam int   AS_WIDTH = 8;
   localparam logic OP_ADD   = 1'b0;
   localparam logic OP_SUB   = 1'b1;

   // Registered result bundle; vectors keep the MSB-at-index-0 ordering of the ports.
   typedef struct packed {
      logic [0:AS_WIDTH-1] s;
      logic                cout;
      logic                ovf;
   } as_result_t;

endpackage

// File: rtl/eight_bit_adder_substractor_full_adder.sv
// Single-bit full adder, the ripple cell of the adder/subtractor chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/eight_bit_adder_substractor.sv
// 8-bit ripple-carry adder/subtractor with registered sum, carry and signed overflow.
// Index 0 is the MSB throughout; the carry ripples from index 7 up to index 0.
module eight_bit_adder_substractor
   import eight_bit_adder_substractor_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [0:AS_WIDTH-1] a,
   input  logic [0:AS_WIDTH-1] b,
   input  logic                sel,
   input  logic                enable,
   output logic [0:AS_WIDTH-1] s,
   output logic                cout,
   output logic                ovf
);

   logic [0:AS_WIDTH-1] bx;
   logic [0:AS_WIDTH-1] sum;
   // c[i+1] is the carry into stage i, c[i] its carry out; c[AS_WIDTH] is the LSB carry-in.
   logic [0:AS_WIDTH]   c;
   as_result_t          nxt;
   as_result_t          res_q;

   // Subtract is a + ~b + 1, so sel both inverts b and supplies the +1.
   assign bx        = b ^ {AS_WIDTH{sel}};
   assign c[AS_WIDTH] = sel;

   genvar i;
   generate
      for (i = 0; i < AS_WIDTH; i++) begin : g_fa
         full_adder u_fa (
            .a    (a[i]),
            .b    (bx[i]),
            .cin  (c[i+1]),
            .sum  (sum[i]),
            .cout (c[i])
         );
      end
   endgenerate

   always_comb begin
      nxt      = '0;
      nxt.s    = sum;
      nxt.cout = c[0];
      nxt.ovf  = c[0] ^ c[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         res_q <= '0;
      else if (enable)
         res_q <= nxt;
   end

   assign s    = res_q.s;
   assign cout = res_q.cout;
   assign ovf  = res_q.ovf;

endmodule

// File: tb/tb_eight_bit_adder_substractor.sv
// Directed-vector bench for eight_bit_adder_substractor with hand-computed expectations.
module tb_eight_bit_adder_substractor;

   logic       clk = 1'b0;
   logic       rst;
   logic [0:7] a, b;
   logic       sel, enable;
   logic [0:7] s;
   logic       cout, ovf;

   int n_chk  = 0;
   int n_fail = 0;

   eight_bit_adder_substractor dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .sel    (sel),
      .enable (enable),
      .s      (s),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_res(input string tag, input int es, input int ec, input int eo);
      chk({tag, ".s"},    int'(s),    es);
      chk({tag, ".cout"}, int'(cout), ec);
      chk({tag, ".ovf"},  int'(ovf),  eo);
   endtask

   // Inputs change 1 time unit after a rising edge and are sampled 1 unit after the next one.
   task automatic run_op(input int va, input int vb, input logic vsel);
      a   = 8'(va);
      b   = 8'(vb);
      sel = vsel;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string tag;
      int    a, b;
      logic  sel;
      int    s, cout, ovf;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs = '{
         '{"add253+2", 253, 2,   1'b0, 255, 0, 0},
         '{"add253+3", 253, 3,   1'b0, 0,   1, 0},
         '{"add253+4", 253, 4,   1'b0, 1,   1, 0},
         '{"add254+2", 254, 2,   1'b0, 0,   1, 0},
         '{"add254+4", 254, 4,   1'b0, 2,   1, 0},
         '{"sub8-2",   8,   2,   1'b1, 6,   1, 0},
         '{"sub9-4",   9,   4,   1'b1, 5,   1, 0},
         '{"sub10-3",  10,  3,   1'b1, 7,   1, 0},
         '{"sub0-0",   0,   0,   1'b1, 0,   1, 0},
         '{"sub2-8",   2,   8,   1'b1, 250, 0, 0},
         '{"ovf127+1", 127, 1,   1'b0, 128, 0, 1},
         '{"ovf128-1", 128, 1,   1'b1, 127, 1, 1},
         '{"add100+20",100, 20,  1'b0, 120, 0, 0}
      };

      rst = 1'b1; enable = 1'b1; sel = 1'b0; a = 8'd5; b = 8'd3;
      #2;
      chk_res("reset", 0, 0, 0);
      @(posedge clk); #1;
      chk_res("reset_dominates_enable", 0, 0, 0);

      rst = 1'b0;
      @(posedge clk); #1;
      chk_res("first_after_reset", 8, 0, 0);

      // Asynchronous reset: outputs clear mid-cycle with no clock edge.
      run_op(255, 1, 1'b0);
      chk_res("wrap255+1", 0, 1, 0);
      run_op(0, 1, 1'b1);
      chk_res("wrap0-1", 255, 0, 0);
      rst = 1'b1;
      #2;
      chk_res("async_reset", 0, 0, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[k]) begin
         run_op(vecs[k].a, vecs[k].b, vecs[k].sel);
         chk_res(vecs[k].tag, vecs[k].s, vecs[k].cout, vecs[k].ovf);
      end

      run_op(77, 77, 1'b1);
      chk_res("sub_x-x", 0, 1, 0);

      // Enable hold.
      run_op(8, 2, 1'b1);
      chk_res("hold_load", 6, 1, 0);
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         run_op(10, 4, 1'b1);
         chk("hold_s", int'(s), 6);
      end
      run_op(200, 100, 1'b0);
      chk_res("hold_diff_operands", 6, 1, 0);
      enable = 1'b1;
      run_op(10, 4, 1'b1);
      chk_res("reenable_10-4", 6, 1, 0);

      // Latency: operands change mid-cycle, output moves only at the next rising edge.
      run_op(50, 25, 1'b0);
      chk("lat_prev", int'(s), 75);
      a = 8'd30; b = 8'd40; sel = 1'b1;
      #3;
      chk("lat_no_comb_s", int'(s), 75);
      chk("lat_no_comb_cout", int'(cout), 0);
      #4;
      chk("lat_before_edge", int'(s), 75);
      @(posedge clk); #1;
      chk_res("lat_after_edge", 246, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
